instr_loader: RTL and testbench

- Front-end loader/controller sitting directly upstream of the MIPS `pipeline` top.
- Receives a byte stream from the UART receiver and decodes single-byte commands.
- Assembles 4 bytes into 32-bit instructions and drives the pipeline's instruction-memory write port (`i_we_IF` / `i_instruction_data`).
- Gates pipeline execution through its halt input: free-run or single-step.

---
 rtl/instr_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// instr_loader: byte-stream command decoder and instruction loader that sits
// in front of the MIPS pipeline. It assembles 4 received bytes (MSB first)
// into 32-bit instructions for the pipeline's instruction-memory write port,
// and gates pipeline execution through o_halt (free-run or single-step).
//
// Commands decoded in IDLE: 'L' load, 'R' run, 'S' single step.
// 'H' aborts a run. Inside LOAD every byte is data.
//
// Optional feature, enabled by defining INSTR_LOADER_TIMEOUT_EN:
// idle-traffic timeout in LOAD. A partial word is dropped after
// TIMEOUT_CYCLES cycles without a byte. A LOAD that sees no bytes at a word
// boundary for that long ends with an o_done pulse.
module instr_loader #(
    parameter int NB_DATA        = 32,
    parameter int NB_BYTE        = 8,
    parameter int MAX_WORDS      = 64,
    parameter int NB_CNT         = 7,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_pipe_halted,
    output logic              o_we_IF,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic              o_halt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [NB_CNT-1:0] o_word_count
);

    localparam int NB_SHIFT = NB_DATA - NB_BYTE;

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_ABORT = NB_BYTE'(8'h48);

    localparam logic [NB_DATA-1:0] HALT_WORD = '1;
    localparam logic [NB_CNT-1:0]  WORD_LIMIT = NB_CNT'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NB_SHIFT-1:0] shift_q, shift_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                we_q, we_d;
    logic [NB_DATA-1:0]  instr_q, instr_d;
    logic                halt_q, halt_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [NB_CNT-1:0]   wcnt_q, wcnt_d;

    // Word formed by the bytes already held plus the byte arriving this cycle.
    logic [NB_DATA-1:0]  word_in;
    assign word_in = {shift_q, i_rx_data};

`ifdef INSTR_LOADER_TIMEOUT_EN
    localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);

    logic [NB_TMO-1:0] tmo_q, tmo_d;
`else
    // The timeout length only matters when the feature is built in.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Next-state and registered-output logic for the loader FSM.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned; that is what keeps this block latch-free.
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        we_d       = 1'b0;
        instr_d    = instr_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        wcnt_d     = wcnt_q;
`ifdef INSTR_LOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d    = ST_LOAD;
                            wcnt_d     = '0;
                            byte_idx_d = '0;
                            ovf_d      = 1'b0;
`ifdef INSTR_LOADER_TIMEOUT_EN
                            tmo_d      = '0;
`endif
                        end
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end

            ST_LOAD: begin
                if (i_rx_valid) begin
`ifdef INSTR_LOADER_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if ((byte_idx_q == 2'd0) && (wcnt_q == WORD_LIMIT)) begin
                        // Session is full: drop the byte and abandon the load.
                        ovf_d      = 1'b1;
                        byte_idx_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        shift_d    = word_in[NB_SHIFT-1:0];
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            we_d    = 1'b1;
                            instr_d = word_in;
                            wcnt_d  = wcnt_q + NB_CNT'(1);
                            if (word_in == HALT_WORD) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
`ifdef INSTR_LOADER_TIMEOUT_EN
                else begin
                    if (tmo_q == TMO_LAST) begin
                        tmo_d = '0;
                        if (byte_idx_q != 2'd0) begin
                            // Drop the partial word but keep loading.
                            byte_idx_d = '0;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tmo_d = tmo_q + NB_TMO'(1);
                    end
                end
`endif
            end

            ST_RUN: begin
                if (i_pipe_halted) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_STEP: begin
                // One unfrozen pipeline clock per 'S'.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // The pipeline runs only in the cycles spent in RUN or STEP.
        halt_d = !((state_d == ST_RUN) || (state_d == ST_STEP));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            we_q       <= 1'b0;
            instr_q    <= '0;
            halt_q     <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            we_q       <= we_d;
            instr_q    <= instr_d;
            halt_q     <= halt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            wcnt_q     <= wcnt_d;
        end
    end

`ifdef INSTR_LOADER_TIMEOUT_EN
    // Idle-traffic counter used only while loading.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign o_we_IF            = we_q;
    assign o_instruction_data = instr_q;
    assign o_halt             = halt_q;
    assign o_busy             = (state_q != ST_IDLE);
    assign o_done             = done_q;
    assign o_overflow         = ovf_q;
    assign o_word_count       = wcnt_q;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
// Self-checking bench for instr_loader. Expected instruction writes are
// queued when their bytes are driven and compared when o_we_IF fires.
// A second instance with MAX_WORDS=2 covers the overflow boundary.
module tb_instr_loader;

    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_CNT  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NB_BYTE-1:0] rx_data;
    logic               rx_valid;
    logic               sel_ovf;
    logic               pipe_halted;

    // Bytes go to the main instance or the small one, never both.
    logic main_valid, ovf_valid;
    assign main_valid = rx_valid & ~sel_ovf;
    assign ovf_valid  = rx_valid & sel_ovf;

    logic               we, halt, busy, done, ovf;
    logic [NB_DATA-1:0] instr;
    logic [NB_CNT-1:0]  wcnt;

    logic               s_we, s_halt, s_busy, s_done, s_ovf;
    logic [NB_DATA-1:0] s_instr;
    logic [NB_CNT-1:0]  s_wcnt;

    instr_loader #(.TIMEOUT_CYCLES(50)) u_dut (
        .clk                (clk),
        .i_rst              (rst),
        .i_rx_data          (rx_data),
        .i_rx_valid         (main_valid),
        .i_pipe_halted      (pipe_halted),
        .o_we_IF            (we),
        .o_instruction_data (instr),
        .o_halt             (halt),
        .o_busy             (busy),
        .o_done             (done),
        .o_overflow         (ovf),
        .o_word_count       (wcnt)
    );

    instr_loader #(.MAX_WORDS(2), .TIMEOUT_CYCLES(50)) u_dut_small (
        .clk                (clk),
        .i_rst              (rst),
        .i_rx_data          (rx_data),
        .i_rx_valid         (ovf_valid),
        .i_pipe_halted      (pipe_halted),
        .o_we_IF            (s_we),
        .o_instruction_data (s_instr),
        .o_halt             (s_halt),
        .o_busy             (s_busy),
        .o_done             (s_done),
        .o_overflow         (s_ovf),
        .o_word_count       (s_wcnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries: {done expected with this write, instruction word}.
    logic [32:0] exp_q[$];

    int halt_low_cnt = 0;
    int halt_win_cnt = 0;
    int done_cnt     = 0;
    int we_cnt       = 0;
    int s_we_cnt     = 0;
    int s_done_cnt   = 0;
    logic halt_prev  = 1'b1;

    // Monitor: samples on the falling edge, pops and compares writes.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            check("we_expected", 33'(exp_q.size() != 0), 33'd1);
            if (exp_q.size() != 0) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("write_word", {done, instr}, e);
            end
        end
        if (halt === 1'b0) halt_low_cnt <= halt_low_cnt + 1;
        if (halt_prev && (halt === 1'b0)) halt_win_cnt <= halt_win_cnt + 1;
        halt_prev <= halt;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (we === 1'b1) we_cnt <= we_cnt + 1;
        if (s_we === 1'b1) s_we_cnt <= s_we_cnt + 1;
        if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back({(w == 32'hFFFF_FFFF), w});
    endtask

    // Bytes on consecutive cycles, rx_valid held high throughout.
    task automatic send_b2b(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            @(negedge clk);
            rx_data  = bytes[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", 33'(exp_q.size()), 33'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b_low, b_win, b_done, b_we, b_swe, b_sdone;
        logic [7:0] stream[$];

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; sel_ovf = 1'b0; pipe_halted = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_we",    33'(we),    33'd0);
        check("rst_instr", 33'(instr), 33'd0);
        check("rst_halt",  33'(halt),  33'd1);
        check("rst_busy",  33'(busy),  33'd0);
        check("rst_done",  33'(done),  33'd0);
        check("rst_ovf",   33'(ovf),   33'd0);
        check("rst_wcnt",  33'(wcnt),  33'd0);
        rst = 1'b0;

        // Basic load of three words ending in HALT.
        #1; b_low = halt_low_cnt; b_done = done_cnt;
        send_byte(8'h4C);
        push_word(32'h2001_0014); send_word(32'h2001_0014);
        push_word(32'h2002_001E); send_word(32'h2002_001E);
        push_word(32'hFFFF_FFFF); send_word(32'hFFFF_FFFF);
        wait_drain();
        repeat (2) @(negedge clk); #1;
        check("load_wcnt",     33'(wcnt), 33'd3);
        check("load_busy",     33'(busy), 33'd0);
        check("load_halt_low", 33'(halt_low_cnt - b_low), 33'd0);
        check("load_done",     33'(done_cnt - b_done), 33'd1);

        // Back-to-back bytes, including one during each write cycle.
        send_byte(8'h4C);
        push_word(32'hA1B2_C3D4); push_word(32'h0BAD_F00D); push_word(32'hFFFF_FFFF);
        stream = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0B, 8'hAD, 8'hF0, 8'h0D,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_b2b(stream);
        wait_drain();
        repeat (2) @(negedge clk); #1;
        check("b2b_wcnt", 33'(wcnt), 33'd3);
        check("b2b_busy", 33'(busy), 33'd0);

        // RUN, pipeline reports halt 12 cycles later.
        b_low = halt_low_cnt; b_done = done_cnt;
        send_byte(8'h52);
        repeat (11) @(negedge clk);
        pipe_halted = 1'b1;
        repeat (3) @(negedge clk);
        pipe_halted = 1'b0;
        #1;
        check("run_halt_low", 33'(halt_low_cnt - b_low), 33'd12);
        check("run_done",     33'(done_cnt - b_done), 33'd1);
        check("run_busy",     33'(busy), 33'd0);
        check("run_halt_end", 33'(halt), 33'd1);

        // RUN entered with the pipeline already halted.
        b_low = halt_low_cnt; b_done = done_cnt;
        pipe_halted = 1'b1;
        send_byte(8'h52);
        repeat (3) @(negedge clk);
        pipe_halted = 1'b0;
        #1;
        check("run0_halt_low", 33'(halt_low_cnt - b_low), 33'd1);
        check("run0_done",     33'(done_cnt - b_done), 33'd1);

        // RUN aborted with 'H'.
        b_done = done_cnt;
        send_byte(8'h52);
        repeat (4) @(negedge clk);
        send_byte(8'h48);
        repeat (2) @(negedge clk); #1;
        check("abort_done", 33'(done_cnt - b_done), 33'd0);
        check("abort_busy", 33'(busy), 33'd0);
        check("abort_halt", 33'(halt), 33'd1);

        // Three single steps.
        b_low = halt_low_cnt; b_win = halt_win_cnt; b_done = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h53);
            repeat (2) @(negedge clk);
        end
        #1;
        check("step_windows",  33'(halt_win_cnt - b_win), 33'd3);
        check("step_halt_low", 33'(halt_low_cnt - b_low), 33'd3);
        check("step_done",     33'(done_cnt - b_done), 33'd0);

        // Overflow on the MAX_WORDS=2 instance.
        do_reset();
        #1; b_swe = s_we_cnt; b_sdone = s_done_cnt; b_we = we_cnt;
        sel_ovf = 1'b1;
        send_byte(8'h4C);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        send_word(32'h0102_0304);
        repeat (3) @(negedge clk); #1;
        check("ovf_writes",   33'(s_we_cnt - b_swe), 33'd2);
        check("ovf_flag",     33'(s_ovf), 33'd1);
        check("ovf_busy",     33'(s_busy), 33'd0);
        check("ovf_done",     33'(s_done_cnt - b_sdone), 33'd0);
        check("ovf_wcnt",     33'(s_wcnt), 33'd2);
        check("ovf_instr",    33'(s_instr), 33'h0_5566_7788);
        check("ovf_main_idle", 33'(we_cnt - b_we), 33'd0);
        send_byte(8'h4C);
        #1;
        check("ovf_clear", 33'(s_ovf), 33'd0);
        check("ovf_reload_busy", 33'(s_busy), 33'd1);
        sel_ovf = 1'b0;

        // Reset in the middle of a word, then a fresh one-word load.
        do_reset();
        #1; b_we = we_cnt;
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        repeat (2) @(negedge clk); #1;
        check("midrst_no_we", 33'(we_cnt - b_we), 33'd0);
        check("midrst_busy",  33'(busy), 33'd0);
        check("midrst_wcnt",  33'(wcnt), 33'd0);
        send_byte(8'h4C);
        push_word(32'h8C22_0004); send_word(32'h8C22_0004);
        wait_drain();
        #1;
        check("midrst_wcnt1", 33'(wcnt), 33'd1);
        check("midrst_load",  33'(busy), 33'd1);

`ifdef INSTR_LOADER_TIMEOUT_EN
        // Partial word dropped after 50 idle cycles, then a full word.
        do_reset();
        #1; b_we = we_cnt; b_done = done_cnt;
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (50) @(negedge clk);
        push_word(32'hCAFE_0001); send_word(32'hCAFE_0001);
        wait_drain();
        #1;
        check("tmo_writes", 33'(we_cnt - b_we), 33'd1);
        check("tmo_wcnt",   33'(wcnt), 33'd1);
        check("tmo_busy",   33'(busy), 33'd1);
        repeat (60) @(negedge clk); #1;
        check("tmo_exit_busy", 33'(busy), 33'd0);
        check("tmo_exit_done", 33'(done_cnt - b_done), 33'd1);
`endif

        do_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
